vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator and pixel output stage for the display path.
//  Generates x/y scan coordinates and accepts a 12-bit color back from a pixel source
//  with PIPE ticks of latency. Emits HS, VS and RGB with all outputs aligned to the same pixel.
//  Adds configurable timing, sync polarity, pixel-clock divider, border and frame/line strobes.
// PARAMETERS
//  CW           10      width of x/y counters; require H_TOTAL, V_TOTAL <= 2**CW
//  H_ACTIVE     640     visible pixels per line
//  H_FP         8       horizontal front porch (pixels)
//  H_PW         96      horizontal sync pulse width (pixels)
//  H_TOTAL      800     pixels per line incl. blanking
//  V_ACTIVE     480     visible lines per frame
//  V_FP         2       vertical front porch (lines)
//  V_PW         2       vertical sync pulse width (lines)
//  V_TOTAL      525     lines per frame
//  BORDER       3       frame border thickness in pixels; 0 = no border
//  BORDER_COLOR 12'h111 RGB shown in the border band
//  HS_POL       0       HS active level (0 = active-low)
//  VS_POL       0       VS active level (0 = active-low)
//  PIPE         0       color latency in pixel ticks after x/y are presented (0..4)
//  CLK_DIV      1       rawClk cycles per pixel tick (>=1)
// PORTS
//  rawClk       in   1     system clock
//  rst          in   1     synchronous, active-high reset
//  en           in   1     run enable; 0 = synchronous soft clear (same effect as rst)
//  color        in   12    {R,G,B} for the coordinate issued PIPE ticks earlier
//  x            out  CW    current horizontal count (pixel address to source)
//  y            out  CW    current vertical count
//  R,G,B        out  4 ea  registered pixel color
//  HS, VS       out  1     registered sync outputs
//  de           out  1     registered: output pixel lies in active area
//  line_start   out  1     one-rawClk pulse with output of pixel x==0
//  frame_start  out  1     one-rawClk pulse with output of pixel (0,0)
// BEHAVIOUR
//  Reset (rst or !en):
//   - x=y=0; divider=0; delay line flushed to blanking.
//   - RGB=0; HS=!HS_POL; VS=!VS_POL; de=line_start=frame_start=0.
//  Pixel tick:
//   - divider counts 0..CLK_DIV-1; tick = (divider==CLK_DIV-1); CLK_DIV=1 -> every cycle.
//   - First tick is CLK_DIV cycles after reset release.
//  Counters (advance on tick only):
//   - x: 0..H_TOTAL-1, wraps to 0.
//   - y: increments when x wraps; at (H_TOTAL-1, V_TOTAL-1) both -> 0.
//   - x/y are driven straight from the counter registers.
//  Delay line:
//   - Per-pixel flags {hs, vs, active, inner, x==0, (x,y)==0} are computed from x/y
//     and shifted PIPE stages on tick.
//   - PIPE=0: no stages; flags are used directly.
//  Output register (updates on tick only, holds between ticks):
//   - The output for pixel p is written on the tick edge at which color for p is sampled,
//     i.e. PIPE ticks after p appears on x/y.
//   - HS = HS_POL when H_ACTIVE+H_FP <= px < H_ACTIVE+H_FP+H_PW, else !HS_POL.
//   - VS = VS_POL when V_ACTIVE+V_FP <= py < V_ACTIVE+V_FP+V_PW, else !VS_POL.
//   - RGB and de:
//     - inner (BORDER <= px < H_ACTIVE-BORDER and BORDER <= py < V_ACTIVE-BORDER): color, de=1.
//     - active but not inner: BORDER_COLOR, de=1.
//     - blanking: 12'h000, de=0.
//  Strobes:
//   - line_start / frame_start assert for exactly one rawClk cycle, on the tick that writes
//     the output for px==0 / (px,py)==(0,0); they are low on all other cycles,
//     including when CLK_DIV>1.
//  Boundaries:
//   - Simultaneous x and y wrap is handled in the same tick.
//   - For the first PIPE ticks after reset, outputs show blanking (flushed stages),
//     never stale sync.
//   - rst or en=0 mid-frame takes effect on the next edge, irrespective of tick.
// TESTING
//  1. Defaults: frame_start period = 420000 rawClk; line_start period = 800; 480 de lines per frame.
//  2. Defaults, PIPE=0: HS low for exactly 96 ticks, starting at the output of px=648;
//     VS low for exactly 2 lines starting at py=482.
//  3. Border, color=12'hFFF: output at (2,10)=111; (3,10)=FFF; (636,10)=FFF;
//     (637,10)=111; (640,10)=000 with de=0.
//  4. PIPE=2, CLK_DIV=2, bench source = 2-tick registered {y[3:0],x[7:0]}:
//     output at (100,50) = 12'h264; x steps every 2 cycles; frame period 840000.
//  5. rst pulse at (300,200): next cycle x=y=0, RGB=0, HS=VS=1; frame_start occurs
//     PIPE ticks after the first tick.
//  6. HS_POL=1, VS_POL=1: sync polarity inverted (idle 0, pulse 1), widths unchanged.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y scan counters, pixel-clock divider,
// and an output stage aligned to a pipelined external pixel source.
module vga_timing_gen #(
    parameter int          CW           = 10,
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 8,
    parameter int          H_PW         = 96,
    parameter int          H_TOTAL      = 800,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 2,
    parameter int          V_PW         = 2,
    parameter int          V_TOTAL      = 525,
    parameter int          BORDER       = 3,
    parameter logic [11:0] BORDER_COLOR = 12'h111,
    parameter bit          HS_POL       = 1'b0,
    parameter bit          VS_POL       = 1'b0,
    parameter int          PIPE         = 0,
    parameter int          CLK_DIV      = 1
) (
    input  logic          rawClk,
    input  logic          rst,
    input  logic          en,
    input  logic [11:0]   color,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [3:0]    R,
    output logic [3:0]    G,
    output logic [3:0]    B,
    output logic          HS,
    output logic          VS,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_PW);
    localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_PW);
    localparam logic [CW:0] H_ACT  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_ACT  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] H_BLO  = (CW+1)'(BORDER);
    localparam logic [CW:0] H_BHI  = (CW+1)'(H_ACTIVE - BORDER);
    localparam logic [CW:0] V_BLO  = (CW+1)'(BORDER);
    localparam logic [CW:0] V_BHI  = (CW+1)'(V_ACTIVE - BORDER);

    // Sync flags are stored as "in pulse" so an all-zero stage means blanking.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic inn;
        logic x0;
        logic f0;
    } flags_t;

    logic            clr;
    logic            tick;
    logic [DIVW-1:0] div;
    logic            x_last;
    logic            y_last;
    logic [CW:0]     xe;
    logic [CW:0]     ye;
    flags_t          cur;
    flags_t          dly;

    assign clr    = rst | ~en;
    assign tick   = (div == DIVW'(CLK_DIV - 1));
    assign x_last = (x == CW'(H_TOTAL - 1));
    assign y_last = (y == CW'(V_TOTAL - 1));
    assign xe     = {1'b0, x};
    assign ye     = {1'b0, y};

    always_ff @(posedge rawClk) begin
        if (clr || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge rawClk) begin
        if (clr) begin
            x <= '0;
            y <= '0;
        end else if (tick) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_comb begin
        cur     = '0;
        cur.hs  = (xe >= HS_BEG) && (xe < HS_END);
        cur.vs  = (ye >= VS_BEG) && (ye < VS_END);
        cur.act = (xe < H_ACT) && (ye < V_ACT);
        cur.inn = (xe >= H_BLO) && (xe < H_BHI) &&
                  (ye >= V_BLO) && (ye < V_BHI);
        cur.x0  = (x == '0);
        cur.f0  = (x == '0) && (y == '0);
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            assign dly = cur;
        end else begin : g_pipe
            flags_t stg [PIPE];
            always_ff @(posedge rawClk) begin
                if (clr) begin
                    for (int i = 0; i < PIPE; i++) stg[i] <= '0;
                end else if (tick) begin
                    stg[0] <= cur;
                    for (int i = 1; i < PIPE; i++) stg[i] <= stg[i-1];
                end
            end
            assign dly = stg[PIPE-1];
        end
    endgenerate

    always_ff @(posedge rawClk) begin
        if (clr) begin
            {R, G, B}   <= 12'h000;
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Strobes are qualified by tick so they last one rawClk cycle.
            line_start  <= tick & dly.x0;
            frame_start <= tick & dly.f0;
            if (tick) begin
                HS <= dly.hs ? HS_POL : ~HS_POL;
                VS <= dly.vs ? VS_POL : ~VS_POL;
                de <= dly.act;
                if (dly.inn) begin
                    {R, G, B} <= color;
                end else if (dly.act) begin
                    {R, G, B} <= BORDER_COLOR;
                end else begin
                    {R, G, B} <= 12'h000;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: three small-raster instances covering
// border/sync placement, pipelined source with divider, and inverted polarity.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic en_on = 1'b1, en2 = 1'b1;
    logic [11:0] c0 = 12'hFFF;
    logic [11:0] c1;
    logic [11:0] c2 = 12'h000;

    logic [9:0] x0, y0, x1, y1, x2, y2;
    logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
    logic hs0, vs0, de0, ls0, fs0;
    logic hs1, vs1, de1, ls1, fs1;
    logic hs2, vs2, de2, ls2, fs2;

    // Small raster: 20x12 active, 30x18 total -> 540 ticks per frame.
    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(2), .H_PW(4), .H_TOTAL(30),
        .V_ACTIVE(12), .V_FP(1), .V_PW(2), .V_TOTAL(18),
        .BORDER(3), .PIPE(0), .CLK_DIV(1)
    ) u0 (
        .rawClk(clk), .rst(rst0), .en(en_on), .color(c0),
        .x(x0), .y(y0), .R(r0), .G(g0), .B(b0),
        .HS(hs0), .VS(vs0), .de(de0),
        .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(2), .H_PW(4), .H_TOTAL(30),
        .V_ACTIVE(12), .V_FP(1), .V_PW(2), .V_TOTAL(18),
        .BORDER(3), .PIPE(2), .CLK_DIV(2)
    ) u1 (
        .rawClk(clk), .rst(rst1), .en(en_on), .color(c1),
        .x(x1), .y(y1), .R(r1), .G(g1), .B(b1),
        .HS(hs1), .VS(vs1), .de(de1),
        .line_start(ls1), .frame_start(fs1)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(2), .H_PW(4), .H_TOTAL(30),
        .V_ACTIVE(12), .V_FP(1), .V_PW(2), .V_TOTAL(18),
        .BORDER(3), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE(1), .CLK_DIV(1)
    ) u2 (
        .rawClk(clk), .rst(rst2), .en(en2), .color(c2),
        .x(x2), .y(y2), .R(r2), .G(g2), .B(b2),
        .HS(hs2), .VS(vs2), .de(de2),
        .line_start(ls2), .frame_start(fs2)
    );

    // Source for u1: {y[3:0],x[7:0]} delayed by two coordinate steps.
    logic [11:0] last = '0, src1 = '0, src2 = '0;
    always @(negedge clk) begin
        if ({y1[3:0], x1[7:0]} != last) begin
            src2 = src1;
            src1 = last;
            last = {y1[3:0], x1[7:0]};
        end
    end
    assign c1 = src2;

    task automatic wait_xy(input int w, input int px, input int py);
        bit hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            case (w)
                0: hit = (x0 == px) && (y0 == py);
                1: hit = (x1 == px) && (y1 == py);
                default: hit = (x2 == px) && (y2 == py);
            endcase
        end
        if (!hit) chk("wait_xy timeout", 0, 1);
    endtask

    task automatic pix0(input int px, input int py);
        wait_xy(0, px, py);
        @(posedge clk);
        #1;
    endtask

    int n, nde, nls;
    bit hit;
    logic [9:0] xv;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst x", x0, 0);
        chk("rst y", y0, 0);
        chk("rst rgb", {r0, g0, b0}, 0);
        chk("rst hs", hs0, 1);
        chk("rst vs", vs0, 1);
        chk("rst de", de0, 0);
        chk("rst fs", fs0, 0);
        chk("rst hs pol", hs2, 0);
        chk("rst vs pol", vs2, 0);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;

        // Border band and blanking on row 5.
        pix0(2, 5);
        chk("b(2,5)", {r0, g0, b0}, 12'h111);
        chk("de(2,5)", de0, 1);
        pix0(3, 5);
        chk("b(3,5)", {r0, g0, b0}, 12'hFFF);
        pix0(16, 5);
        chk("b(16,5)", {r0, g0, b0}, 12'hFFF);
        pix0(17, 5);
        chk("b(17,5)", {r0, g0, b0}, 12'h111);
        pix0(20, 5);
        chk("b(20,5)", {r0, g0, b0}, 12'h000);
        chk("de(20,5)", de0, 0);
        pix0(21, 5);
        chk("hs(21,5)", hs0, 1);
        pix0(22, 5);
        chk("hs(22,5)", hs0, 0);
        pix0(25, 5);
        chk("hs(25,5)", hs0, 0);
        pix0(26, 5);
        chk("hs(26,5)", hs0, 1);
        pix0(0, 6);
        chk("ls(0,6)", ls0, 1);
        chk("fs(0,6)", fs0, 0);
        pix0(10, 11);
        chk("b(10,11)", {r0, g0, b0}, 12'h111);
        pix0(29, 12);
        chk("vs(29,12)", vs0, 1);
        pix0(0, 13);
        chk("vs(0,13)", vs0, 0);
        pix0(29, 14);
        chk("vs(29,14)", vs0, 0);
        pix0(0, 15);
        chk("vs(0,15)", vs0, 1);

        // Frame and line periods, de count per frame.
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            hit = fs0;
        end
        chk("fs0 seen", hit, 1);
        n = 0; nde = 0; nls = 0;
        do begin
            @(negedge clk);
            n++;
            if (de0) nde++;
            if (ls0) nls++;
        end while (!fs0 && n < 2000);
        chk("frame period", n, 540);
        chk("de per frame", nde, 240);
        chk("lines per frame", nls, 18);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ls0 && n < 2000);
        chk("line period", n, 30);

        // Mid-frame reset, PIPE=0.
        wait_xy(0, 15, 8);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst x", x0, 0);
        chk("mrst y", y0, 0);
        chk("mrst rgb", {r0, g0, b0}, 0);
        chk("mrst hs", hs0, 1);
        chk("mrst vs", vs0, 1);
        @(negedge clk);
        rst0 = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!fs0 && n < 50);
        chk("u0 fs latency", n, 1);

        // u1: divided tick, 2-deep pipelined source.
        hit = 1'b0;
        xv = x1;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            hit = (x1 != xv);
            xv = x1;
        end
        @(negedge clk);
        chk("x1 hold", x1, xv);
        @(negedge clk);
        chk("x1 step", x1, xv + 10'd1);
        wait_xy(1, 10, 5);
        repeat (6) @(posedge clk);
        #1;
        chk("u1 (10,5) rgb", {r1, g1, b1}, 12'h50A);
        chk("u1 (10,5) de", de1, 1);
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            hit = fs1;
        end
        chk("fs1 seen", hit, 1);
        @(negedge clk);
        chk("fs1 width", fs1, 0);
        n = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!fs1 && n < 3000);
        chk("u1 frame period", n, 1080);

        wait_xy(1, 7, 3);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        chk("u1 mrst x", x1, 0);
        chk("u1 mrst y", y1, 0);
        chk("u1 mrst hs", hs1, 1);
        @(negedge clk);
        rst1 = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 2) chk("u1 flush hs", hs1, 1);
            if (n == 4) chk("u1 flush de", de1, 0);
        end while (!fs1 && n < 50);
        chk("u1 fs latency", n, 6);

        // u2: inverted sync polarity, PIPE=1.
        wait_xy(2, 22, 4);
        repeat (2) @(posedge clk);
        #1;
        chk("u2 hs(22,4)", hs2, 1);
        wait_xy(2, 21, 5);
        repeat (2) @(posedge clk);
        #1;
        chk("u2 hs(21,5)", hs2, 0);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            hit = hs2;
        end
        n = 0;
        while (hs2 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("u2 hs width", n, 4);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            hit = vs2;
        end
        n = 0;
        while (vs2 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("u2 vs width", n, 60);

        // Soft clear through en.
        wait_xy(2, 24, 13);
        en2 = 1'b0;
        @(posedge clk);
        #1;
        chk("en0 x", x2, 0);
        chk("en0 y", y2, 0);
        chk("en0 hs", hs2, 0);
        chk("en0 vs", vs2, 0);
        @(negedge clk);
        en2 = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
